// File: rtl/alu_src_pkg.sv
// Operand-source encodings for the ALU operand stage, shared with the decoder.
package alu_src_pkg;

  typedef enum logic [1:0] {
    SRC_A_RS1     = 2'b00,
    SRC_A_ZERO    = 2'b01,
    SRC_A_PC      = 2'b10,
    SRC_A_ILLEGAL = 2'b11
  } src_a_e;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_e;

endpackage

// File: rtl/fwd_resolve.sv
// Resolves one source register against the forwarding sources; the youngest
// matching writer wins, and a matching writer with pending load data raises hazard.
module fwd_resolve #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2
) (
  input  logic [REG_ADDR_W-1:0]            i_addr,
  input  logic [XLEN-1:0]                  i_rd_val,
  input  logic [FWD_STAGES-1:0]            i_fwd_we,
  input  logic [FWD_STAGES-1:0]            i_fwd_pending,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] i_fwd_rd,
  input  logic [FWD_STAGES*XLEN-1:0]       i_fwd_data,
  output logic [XLEN-1:0]                  o_data,
  output logic                             o_hazard
);

  logic w_hit;

  always_comb begin
    w_hit    = 1'b0;
    o_data   = i_rd_val;
    o_hazard = 1'b0;
    for (int unsigned i = 0; i < FWD_STAGES; i++) begin
      if (!w_hit && i_fwd_we[i] && (i_fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == i_addr)) begin
        w_hit = 1'b1;
        if (i_fwd_pending[i]) o_hazard = 1'b1;
        else                  o_data   = i_fwd_data[i*XLEN +: XLEN];
      end
    end
    // x0 is hardwired: never forwarded, never stalls.
    if (i_addr == '0) begin
      o_data   = '0;
      o_hazard = 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage: forwarding, A/B selection, load-use
// hazard detection and a single-entry valid/ready output register.
module alu_operand_stage
  import alu_src_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       ALUSrc_A,
  input  logic                             ALUSrc_B,
  input  logic [REG_ADDR_W-1:0]            rs1,
  input  logic [REG_ADDR_W-1:0]            rs2,
  input  logic [XLEN-1:0]                  RD1,
  input  logic [XLEN-1:0]                  RD2,
  input  logic [XLEN-1:0]                  PC,
  input  logic [XLEN-1:0]                  Imm,
  input  logic [FWD_STAGES-1:0]            fwd_we,
  input  logic [FWD_STAGES-1:0]            fwd_pending,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
  input  logic [FWD_STAGES*XLEN-1:0]       fwd_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  A,
  output logic [XLEN-1:0]                  B,
  output logic [XLEN-1:0]                  store_data,
  output logic                             illegal_sel,
  output logic [31:0]                      stall_cnt
);

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_rs1_haz;
  logic            w_rs2_haz;
  logic            w_hazard;
  logic            w_can_load;
  logic            w_capture;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_illegal;

  logic            r_out_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_store_data;
  logic            r_illegal;
  logic [31:0]     r_stall_cnt;

  fwd_resolve #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES)
  ) u_fwd_rs1 (
    .i_addr        (rs1),
    .i_rd_val      (RD1),
    .i_fwd_we      (fwd_we),
    .i_fwd_pending (fwd_pending),
    .i_fwd_rd      (fwd_rd),
    .i_fwd_data    (fwd_data),
    .o_data        (w_rs1_val),
    .o_hazard      (w_rs1_haz)
  );

  fwd_resolve #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES)
  ) u_fwd_rs2 (
    .i_addr        (rs2),
    .i_rd_val      (RD2),
    .i_fwd_we      (fwd_we),
    .i_fwd_pending (fwd_pending),
    .i_fwd_rd      (fwd_rd),
    .i_fwd_data    (fwd_data),
    .o_data        (w_rs2_val),
    .o_hazard      (w_rs2_haz)
  );

  // RS2 always matters because store_data carries it regardless of ALUSrc_B.
  assign w_hazard   = in_valid && (((ALUSrc_A == SRC_A_RS1) && w_rs1_haz) || w_rs2_haz);
  assign w_can_load = !r_out_valid || out_ready;
  assign in_ready   = flush || (w_can_load && !w_hazard);
  assign w_capture  = in_valid && in_ready && !flush;

  always_comb begin
    w_a       = '0;
    w_illegal = 1'b0;
    unique case (ALUSrc_A)
      SRC_A_RS1:     w_a = w_rs1_val;
      SRC_A_ZERO:    w_a = '0;
      SRC_A_PC:      w_a = PC;
      SRC_A_ILLEGAL: w_illegal = 1'b1;
      default:       w_a = '0;
    endcase
  end

  assign w_b = (ALUSrc_B == SRC_B_IMM) ? Imm : w_rs2_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_illegal    <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_a          <= w_a;
      r_b          <= w_b;
      r_store_data <= w_rs2_val;
      r_illegal    <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign out_valid   = r_out_valid;
  assign A           = r_a;
  assign B           = r_b;
  assign store_data  = r_store_data;
  assign illegal_sel = r_illegal;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with an expected-result scoreboard.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUSrc_A;
  logic        ALUSrc_B;
  logic [4:0]  rs1, rs2;
  logic [31:0] RD1, RD2, PC, Imm;
  logic [1:0]  fwd_we, fwd_pending;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A, B, store_data;
  logic        illegal_sel;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic [31:0] exp_stall = 0;

  alu_operand_stage #(
    .XLEN       (32),
    .REG_ADDR_W (5),
    .FWD_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUSrc_A    (ALUSrc_A),
    .ALUSrc_B    (ALUSrc_B),
    .rs1         (rs1),
    .rs2         (rs2),
    .RD1         (RD1),
    .RD2         (RD2),
    .PC          (PC),
    .Imm         (Imm),
    .fwd_we      (fwd_we),
    .fwd_pending (fwd_pending),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .A           (A),
    .B           (B),
    .store_data  (store_data),
    .illegal_sel (illegal_sel),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, in_ready}, {31'd0, exp});
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] sd, input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.sd = sd; e.ill = ill;
    q.push_back(e);
  endtask

  task automatic edge_cap(input string tag);
    exp_t e;
    @(posedge clk); #1;
    e = q.pop_front();
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".A"}, A, e.a);
    check({tag, ".B"}, B, e.b);
    check({tag, ".sd"}, store_data, e.sd);
    check({tag, ".ill"}, {31'd0, illegal_sel}, {31'd0, e.ill});
  endtask

  task automatic edge_nocap(input string tag, input logic exp_valid);
    @(posedge clk); #1;
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
  endtask

  task automatic op(input logic [1:0] sa, input logic sb, input logic [4:0] r1,
                    input logic [4:0] r2, input logic [31:0] d1, input logic [31:0] d2,
                    input logic [31:0] pc, input logic [31:0] imm);
    in_valid = 1'b1;
    ALUSrc_A = sa; ALUSrc_B = sb;
    rs1 = r1; rs2 = r2; RD1 = d1; RD2 = d2; PC = pc; Imm = imm;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ALUSrc_A = 2'b00; ALUSrc_B = 1'b0; rs1 = '0; rs2 = '0;
    RD1 = '0; RD2 = '0; PC = '0; Imm = '0;
    fwd_we = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.A", A, 32'd0);
    check("rst.B", B, 32'd0);
    check("rst.sd", store_data, 32'd0);
    check("rst.ill", {31'd0, illegal_sel}, 32'd0);
    check("rst.stall", stall_cnt, 32'd0);

    // PC + immediate
    op(2'b10, 1'b1, 5'd1, 5'd3, 32'hDEAD, 32'h33, 32'h0000_1000, 32'hFFFF_FFFC);
    check_ready("pcimm.rdy", 1'b1);
    push(32'h1000, 32'hFFFF_FFFC, 32'h33, 1'b0);
    edge_cap("pcimm");

    // forwarding priority, back-to-back
    op(2'b00, 1'b0, 5'd5, 5'd9, 32'h11, 32'h99, 32'h0, 32'h0);
    fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA};
    check_ready("fwd0.rdy", 1'b1);
    push(32'hAA, 32'h99, 32'h99, 1'b0);
    edge_cap("fwd0");
    fwd_we = 2'b10;
    push(32'hBB, 32'h99, 32'h99, 1'b0);
    edge_cap("fwd1");
    fwd_we = 2'b11; rs1 = 5'd0;
    push(32'h0, 32'h99, 32'h99, 1'b0);
    edge_cap("x0rs1");
    fwd_rd = {5'd0, 5'd0}; rs2 = 5'd0; RD2 = 32'h77;
    push(32'h0, 32'h0, 32'h0, 1'b0);
    edge_cap("x0fwd");

    // load-use stall on rs2 (rs1 hazard ignored with ALUSrc_A=01)
    op(2'b01, 1'b0, 5'd7, 5'd7, 32'h70, 32'h71, 32'h0, 32'h0);
    fwd_we = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_pending = 2'b01; fwd_data = '0;
    for (int i = 0; i < 2; i++) begin
      check_ready("stall.rdy", 1'b0);
      edge_nocap("stall", 1'b0);
      exp_stall++;
      check("stall.cnt", stall_cnt, exp_stall);
    end
    fwd_pending = 2'b00; fwd_data = {32'h0, 32'h55};
    check_ready("unstall.rdy", 1'b1);
    push(32'h0, 32'h55, 32'h55, 1'b0);
    edge_cap("unstall");
    check("unstall.cnt", stall_cnt, exp_stall);

    // back-pressure holds output and blocks input
    fwd_we = '0;
    op(2'b10, 1'b1, 5'd1, 5'd2, 32'h0, 32'h22, 32'h2000, 32'h10);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_ready("hold.rdy", 1'b0);
      edge_nocap("hold", 1'b1);
      check("hold.A", A, 32'h0);
      check("hold.B", B, 32'h55);
    end
    out_ready = 1'b1;
    check_ready("release.rdy", 1'b1);
    push(32'h2000, 32'h10, 32'h22, 1'b0);
    edge_cap("release");

    // flush with held output and load-use hazard
    out_ready = 1'b0;
    op(2'b00, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0);
    fwd_we = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_pending = 2'b01;
    flush = 1'b1;
    check_ready("flush.rdy", 1'b1);
    edge_nocap("flush", 1'b0);
    check("flush.ill", {31'd0, illegal_sel}, 32'd0);
    check("flush.cnt", stall_cnt, exp_stall);
    flush = 1'b0; in_valid = 1'b0; fwd_pending = 2'b00; out_ready = 1'b1;
    edge_nocap("postflush", 1'b0);

    // illegal source A
    fwd_we = '0;
    op(2'b11, 1'b1, 5'd4, 5'd2, 32'h1234, 32'h22, 32'h0, 32'h8);
    push(32'h0, 32'h8, 32'h22, 1'b1);
    edge_cap("illegal");
    in_valid = 1'b0;
    edge_nocap("drain", 1'b0);
    check("drain.ill", {31'd0, illegal_sel}, 32'd0);

    // reset mid-stall with a held output
    op(2'b10, 1'b1, 5'd1, 5'd2, 32'h0, 32'h66, 32'h3000, 32'h4);
    push(32'h3000, 32'h4, 32'h66, 1'b0);
    edge_cap("prerst");
    out_ready = 1'b0;
    op(2'b00, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0);
    fwd_we = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_pending = 2'b01;
    check_ready("rststall.rdy", 1'b0);
    edge_nocap("rststall", 1'b1);
    exp_stall++;
    check("rststall.cnt", stall_cnt, exp_stall);
    rst = 1'b1;
    edge_nocap("midrst", 1'b0);
    check("midrst.A", A, 32'h0);
    check("midrst.B", B, 32'h0);
    check("midrst.sd", store_data, 32'h0);
    check("midrst.ill", {31'd0, illegal_sel}, 32'd0);
    check("midrst.cnt", stall_cnt, 32'd0);
    rst = 1'b0; in_valid = 1'b0; fwd_pending = '0; out_ready = 1'b1;
    edge_nocap("postrst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
